// File: rtl/axi_pkg.sv
// Shared AXI definitions for the read-channel master.
//   BURST_INCR, RESP_OKAY / RESP_SLVERR, ARCACHE_DEFAULT : protocol constants
//   axi_size()   : ARSIZE encoding for a given data-bus width in bits
//   rd_state_t   : 2-bit state encoding of the read master FSM
package axi_pkg;

    localparam logic [1:0] BURST_INCR      = 2'b01;
    localparam logic [1:0] RESP_OKAY       = 2'b00;
    localparam logic [1:0] RESP_SLVERR     = 2'b10;
    localparam logic [3:0] ARCACHE_DEFAULT = 4'b0011;

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_AR   = 2'd1,
        RD_R    = 2'd2,
        RD_DONE = 2'd3
    } rd_state_t;

    // ARSIZE = log2(bytes per beat)
    function automatic logic [2:0] axi_size(input int data_width);
        return 3'($clog2(data_width / 8));
    endfunction

endpackage

// File: rtl/axi_master_rd.sv
// AXI4 read-channel master (AR + R). Accepts one burst request from the user side,
// issues it on AR, and forwards every R beat to the user side with back-pressure.
//
// Ports
//   clk, rst                 : single clock, synchronous active-high reset
//   rd_start/rd_addr/rd_len  : user burst request (accepted only while rd_ready=1)
//   rd_ready                 : master idle
//   rd_fifo_full             : user sink full, holds off R beats
//   rd_data/rd_data_valid    : forwarded beat, valid exactly on R handshakes
//   rd_done                  : one-cycle pulse after the last beat
//   rd_err                   : sticky response/length error flag
//   m_axi_ar* / m_axi_r*     : AXI4 read address and read data channels
//
// Build option
//   RD_RESP_CHK_EN : when defined, rd_err flags non-OKAY responses and rlast/length
//                    disagreement; when undefined rd_err is tied low.
module axi_master_rd
    import axi_pkg::*;
#(
    parameter logic [3:0] AXI_ID     = 4'b0000,
    parameter int         ADDR_WIDTH = 30,
    parameter int         DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  rd_start,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [7:0]            rd_len,
    output logic                  rd_ready,
    input  logic                  rd_fifo_full,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_data_valid,
    output logic                  rd_done,
    output logic                  rd_err,

    output logic [3:0]            m_axi_arid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arlock,
    output logic [3:0]            m_axi_arcache,
    output logic [2:0]            m_axi_arprot,
    output logic [3:0]            m_axi_arqos,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,

    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);

    localparam logic [2:0] AR_SIZE = axi_size(DATA_WIDTH);

    rd_state_t  state;
    rd_state_t  state_nxt;
    logic [7:0] cnt;
    logic       r_hs;

    // Constant AR attributes
    assign m_axi_arsize  = AR_SIZE;
    assign m_axi_arburst = BURST_INCR;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = ARCACHE_DEFAULT;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arqos   = 4'b0000;

    // Handshake-facing outputs decode directly from the registered state, so arvalid
    // cannot drop until the FSM has seen arready.
    assign rd_ready      = (state == RD_IDLE);
    assign m_axi_arvalid = (state == RD_AR);
    assign m_axi_rready  = (state == RD_R) && !rd_fifo_full;
    assign r_hs          = m_axi_rvalid && m_axi_rready;
    assign rd_data_valid = r_hs;
    assign rd_data       = m_axi_rdata;
    assign rd_done       = (state == RD_DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            RD_IDLE: if (rd_start)            state_nxt = RD_AR;
            RD_AR:   if (m_axi_arready)       state_nxt = RD_R;
            // The burst ends on rlast alone; cnt only feeds the optional checker.
            RD_R:    if (r_hs && m_axi_rlast) state_nxt = RD_DONE;
            RD_DONE:                          state_nxt = RD_IDLE;
            default:                          state_nxt = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RD_IDLE;
            m_axi_arid   <= '0;
            m_axi_araddr <= '0;
            m_axi_arlen  <= '0;
            cnt          <= '0;
        end else begin
            state <= state_nxt;
            if (state == RD_IDLE && rd_start) begin
                m_axi_arid   <= AXI_ID;
                m_axi_araddr <= rd_addr;
                m_axi_arlen  <= rd_len;
                cnt          <= '0;
            end else if (r_hs) begin
                cnt <= cnt + 8'd1;
            end
        end
    end

`ifdef RD_RESP_CHK_EN
    logic err_q;

    // cnt holds the index of the current beat, so rlast must coincide exactly with
    // cnt == arlen; either side alone is a length violation.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (r_hs && ((m_axi_rresp != RESP_OKAY) ||
                              (m_axi_rlast != (cnt == m_axi_arlen)))) begin
            err_q <= 1'b1;
        end
    end

    assign rd_err = err_q;
`else
    logic unused_chk;
    assign unused_chk = ^{m_axi_rresp, cnt};
    assign rd_err     = 1'b0;
`endif

endmodule

// File: tb/tb_axi_master_rd.sv
// Directed testbench for axi_master_rd. The bench plays the AXI slave and the user
// sink; inputs change 1 ns after the rising edge and outputs are sampled 1 ns later.
module tb_axi_master_rd;
    import axi_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd_start = 1'b0;
    logic [29:0] rd_addr = '0;
    logic [7:0]  rd_len = '0;
    logic        rd_ready;
    logic        rd_fifo_full = 1'b0;
    logic [63:0] rd_data;
    logic        rd_data_valid;
    logic        rd_done;
    logic        rd_err;
    logic [3:0]  m_axi_arid;
    logic [29:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic        m_axi_arlock;
    logic [3:0]  m_axi_arcache;
    logic [2:0]  m_axi_arprot;
    logic [3:0]  m_axi_arqos;
    logic        m_axi_arvalid;
    logic        m_axi_arready = 1'b0;
    logic [63:0] m_axi_rdata = '0;
    logic [1:0]  m_axi_rresp = 2'b00;
    logic        m_axi_rlast = 1'b0;
    logic        m_axi_rvalid = 1'b0;
    logic        m_axi_rready;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef RD_RESP_CHK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    always #5 clk = ~clk;

    axi_master_rd dut (
        .clk(clk), .rst(rst),
        .rd_start(rd_start), .rd_addr(rd_addr), .rd_len(rd_len), .rd_ready(rd_ready),
        .rd_fifo_full(rd_fifo_full), .rd_data(rd_data), .rd_data_valid(rd_data_valid),
        .rd_done(rd_done), .rd_err(rd_err),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
        .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        cyc();
    endtask

    // Requests one burst and completes the AR handshake after ar_wait stall cycles.
    // Returns the number of cycles arvalid was seen high (handshake cycle included)
    // and the address fields as seen in the first AR cycle. Ends in the first R cycle.
    task automatic issue(input logic [29:0] addr, input logic [7:0] len, input int ar_wait,
                         output int arv_cycles, output logic [29:0] got_addr,
                         output logic [7:0] got_len);
        rd_start = 1'b1; rd_addr = addr; rd_len = len;
        cyc();
        rd_start = 1'b0; rd_addr = '0; rd_len = '0;
        arv_cycles = 0;
        got_addr = m_axi_araddr;
        got_len  = m_axi_arlen;
        for (int i = 0; i < ar_wait; i++) begin
            m_axi_arready = 1'b0;
            #1;
            if (m_axi_arvalid) arv_cycles++;
            cyc();
        end
        m_axi_arready = 1'b1;
        #1;
        if (m_axi_arvalid) arv_cycles++;
        cyc();
        m_axi_arready = 1'b0;
    endtask

    // Slave keeps rvalid high; beat k carries data {A5A50000, k}, rlast on beat last_at,
    // SLVERR on beat err_beat. With toggle_full the sink is full on cycles 2,3,6,7,...
    // A beat is expected to transfer exactly when the sink is not full.
    task automatic recv(input int last_at, input int err_beat, input bit toggle_full,
                        output int nbeats, output int bad_data, output int bad_rready,
                        output bit timeout);
        int  cycle;
        bit  hs_exp;
        cycle = 0; nbeats = 0; bad_data = 0; bad_rready = 0; timeout = 1'b0;
        while (1) begin
            if (cycle > 300) begin
                timeout = 1'b1;
                break;
            end
            rd_fifo_full = toggle_full ? (((cycle / 2) % 2) == 1) : 1'b0;
            m_axi_rvalid = 1'b1;
            m_axi_rdata  = {32'hA5A5_0000, 32'(nbeats)};
            m_axi_rlast  = (nbeats == last_at);
            m_axi_rresp  = (nbeats == err_beat) ? RESP_SLVERR : RESP_OKAY;
            hs_exp = !rd_fifo_full;
            #1;
            if (m_axi_rready !== hs_exp || rd_data_valid !== hs_exp) bad_rready++;
            if (hs_exp && rd_data !== {32'hA5A5_0000, 32'(nbeats)}) bad_data++;
            cycle++;
            cyc();
            if (hs_exp) begin
                nbeats++;
                if (nbeats == last_at + 1) break;
            end
        end
        m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_rresp = RESP_OKAY;
        rd_fifo_full = 1'b0; m_axi_rdata = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc(); cyc(); cyc();
        n_tests++;
        if (rd_ready !== 1'b1 || m_axi_arvalid !== 1'b0 || m_axi_rready !== 1'b0 ||
            rd_done !== 1'b0 || rd_err !== 1'b0 || rd_data_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: ready=%b arvalid=%b rready=%b done=%b err=%b dv=%b, need 1 0 0 0 0 0",
                     rd_ready, m_axi_arvalid, m_axi_rready, rd_done, rd_err, rd_data_valid);
        end
        n_tests++;
        if (m_axi_arid !== 4'h0 || m_axi_araddr !== 30'h0 || m_axi_arlen !== 8'h0) begin
            n_fail++;
            $display("FAIL reset_fields: id=%h addr=%h len=%h, need 0 0 0",
                     m_axi_arid, m_axi_araddr, m_axi_arlen);
        end
        n_tests++;
        if (m_axi_arsize !== 3'b011 || m_axi_arburst !== 2'b01 || m_axi_arlock !== 1'b0 ||
            m_axi_arcache !== 4'b0011 || m_axi_arprot !== 3'b000 || m_axi_arqos !== 4'b0000) begin
            n_fail++;
            $display("FAIL ar_const: size=%b burst=%b lock=%b cache=%b prot=%b qos=%b, need 011 01 0 0011 000 0000",
                     m_axi_arsize, m_axi_arburst, m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arqos);
        end
        rst = 1'b0;
        cyc();
        n_tests++;
        if (rd_ready !== 1'b1 || m_axi_arvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: ready=%b arvalid=%b, need 1 0", rd_ready, m_axi_arvalid);
        end
    endtask

    task automatic test_burst8();
        int arv, nb, bd, br;
        bit to;
        logic [29:0] a;
        logic [7:0]  l;
        issue(30'h100, 8'd7, 3, arv, a, l);
        n_tests++;
        if (a !== 30'h100 || l !== 8'd7 || arv != 4) begin
            n_fail++;
            $display("FAIL b8_ar: addr=%h len=%0d arvalid_cycles=%0d, need 100 7 4", a, l, arv);
        end
        n_tests++;
        if (m_axi_arvalid !== 1'b0 || m_axi_rready !== 1'b1) begin
            n_fail++;
            $display("FAIL b8_enter_r: arvalid=%b rready=%b, need 0 1", m_axi_arvalid, m_axi_rready);
        end
        recv(7, -1, 1'b0, nb, bd, br, to);
        n_tests++;
        if (to || nb != 8 || bd != 0 || br != 0) begin
            n_fail++;
            $display("FAIL b8_beats: timeout=%0d beats=%0d bad_data=%0d bad_rready=%0d, need 0 8 0 0",
                     to, nb, bd, br);
        end
        n_tests++;
        if (rd_done !== 1'b1 || m_axi_rready !== 1'b0 || rd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL b8_done: done=%b rready=%b ready=%b, need 1 0 0", rd_done, m_axi_rready, rd_ready);
        end
        cyc();
        n_tests++;
        if (rd_done !== 1'b0 || rd_ready !== 1'b1 || rd_err !== 1'b0) begin
            n_fail++;
            $display("FAIL b8_idle: done=%b ready=%b err=%b, need 0 1 0", rd_done, rd_ready, rd_err);
        end
    endtask

    task automatic test_len0();
        int arv, nb, bd, br;
        bit to;
        logic [29:0] a;
        logic [7:0]  l;
        issue(30'h2000, 8'd0, 0, arv, a, l);
        n_tests++;
        if (a !== 30'h2000 || l !== 8'd0 || arv != 1) begin
            n_fail++;
            $display("FAIL len0_ar: addr=%h len=%0d arvalid_cycles=%0d, need 2000 0 1", a, l, arv);
        end
        recv(0, -1, 1'b0, nb, bd, br, to);
        n_tests++;
        if (to || nb != 1 || bd != 0 || br != 0 || rd_done !== 1'b1) begin
            n_fail++;
            $display("FAIL len0_beat: timeout=%0d beats=%0d bad_data=%0d bad_rready=%0d done=%b, need 0 1 0 0 1",
                     to, nb, bd, br, rd_done);
        end
        cyc();
        n_tests++;
        if (rd_done !== 1'b0 || rd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL len0_idle: done=%b ready=%b, need 0 1", rd_done, rd_ready);
        end
    endtask

    task automatic test_fifo_full();
        int arv, nb, bd, br;
        bit to;
        logic [29:0] a;
        logic [7:0]  l;
        issue(30'h300, 8'd15, 1, arv, a, l);
        recv(15, -1, 1'b1, nb, bd, br, to);
        n_tests++;
        if (to || nb != 16 || bd != 0 || br != 0) begin
            n_fail++;
            $display("FAIL full_beats: timeout=%0d beats=%0d bad_data=%0d bad_rready=%0d, need 0 16 0 0",
                     to, nb, bd, br);
        end
        n_tests++;
        if (rd_done !== 1'b1) begin
            n_fail++;
            $display("FAIL full_done: done=%b, need 1", rd_done);
        end
        cyc();
    endtask

    task automatic test_back_to_back();
        int nb, bd, br;
        bit to;
        rd_start = 1'b1; rd_addr = 30'h400; rd_len = 8'd1;
        cyc();
        // rd_start stays high with a new request; it must be ignored while busy
        rd_addr = 30'h500; rd_len = 8'd0;
        m_axi_arready = 1'b0;
        #1;
        cyc();
        n_tests++;
        if (m_axi_arvalid !== 1'b1 || m_axi_araddr !== 30'h400 || m_axi_arlen !== 8'd1 || rd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_ar_hold: arvalid=%b addr=%h len=%0d ready=%b, need 1 400 1 0",
                     m_axi_arvalid, m_axi_araddr, m_axi_arlen, rd_ready);
        end
        m_axi_arready = 1'b1;
        cyc();
        m_axi_arready = 1'b0;
        recv(1, -1, 1'b0, nb, bd, br, to);
        n_tests++;
        if (to || nb != 2 || bd != 0 || br != 0 || rd_done !== 1'b1 || m_axi_araddr !== 30'h400) begin
            n_fail++;
            $display("FAIL busy_burst: timeout=%0d beats=%0d bad_data=%0d bad_rready=%0d done=%b addr=%h, need 0 2 0 0 1 400",
                     to, nb, bd, br, rd_done, m_axi_araddr);
        end
        cyc();
        n_tests++;
        if (rd_ready !== 1'b1 || m_axi_arvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_gap: ready=%b arvalid=%b, need 1 0", rd_ready, m_axi_arvalid);
        end
        cyc();
        rd_start = 1'b0;
        n_tests++;
        if (m_axi_arvalid !== 1'b1 || m_axi_araddr !== 30'h500 || m_axi_arlen !== 8'd0) begin
            n_fail++;
            $display("FAIL b2b_second_ar: arvalid=%b addr=%h len=%0d, need 1 500 0",
                     m_axi_arvalid, m_axi_araddr, m_axi_arlen);
        end
        m_axi_arready = 1'b1;
        cyc();
        m_axi_arready = 1'b0;
        recv(0, -1, 1'b0, nb, bd, br, to);
        n_tests++;
        if (to || nb != 1 || rd_done !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_second_burst: timeout=%0d beats=%0d done=%b, need 0 1 1", to, nb, rd_done);
        end
        cyc();
    endtask

    task automatic test_reset_mid();
        int arv;
        int done_seen;
        logic [29:0] a;
        logic [7:0]  l;
        issue(30'h600, 8'd7, 0, arv, a, l);
        for (int i = 0; i < 2; i++) begin
            m_axi_rvalid = 1'b1; m_axi_rdata = {32'hA5A5_0000, 32'(i)}; m_axi_rlast = 1'b0;
            cyc();
        end
        m_axi_rvalid = 1'b1; m_axi_rdata = {32'hA5A5_0000, 32'd2};
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        n_tests++;
        if (m_axi_arvalid !== 1'b0 || m_axi_rready !== 1'b0 || rd_ready !== 1'b1 ||
            rd_done !== 1'b0 || rd_data_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid: arvalid=%b rready=%b ready=%b done=%b dv=%b, need 0 0 1 0 0",
                     m_axi_arvalid, m_axi_rready, rd_ready, rd_done, rd_data_valid);
        end
        done_seen = 0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            if (rd_done === 1'b1 || m_axi_arvalid === 1'b1) done_seen++;
        end
        m_axi_rvalid = 1'b0;
        n_tests++;
        if (done_seen != 0) begin
            n_fail++;
            $display("FAIL rst_mid_quiet: done/arvalid seen %0d cycles, need 0", done_seen);
        end
    endtask

    task automatic test_resp_err();
        int arv, nb, bd, br;
        bit to;
        logic [29:0] a;
        logic [7:0]  l;
        do_reset();
        issue(30'h700, 8'd3, 0, arv, a, l);
        recv(3, 2, 1'b0, nb, bd, br, to);
        n_tests++;
        if (to || nb != 4 || bd != 0 || rd_err !== ERR_EXP) begin
            n_fail++;
            $display("FAIL err_slverr: timeout=%0d beats=%0d bad_data=%0d err=%b, need 0 4 0 %b",
                     to, nb, bd, rd_err, ERR_EXP);
        end
        cyc(); cyc();
        n_tests++;
        if (rd_err !== ERR_EXP) begin
            n_fail++;
            $display("FAIL err_sticky: err=%b, need %b", rd_err, ERR_EXP);
        end
        do_reset();
        n_tests++;
        if (rd_err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_cleared: err=%b, need 0", rd_err);
        end
        issue(30'h800, 8'd7, 0, arv, a, l);
        recv(3, -1, 1'b0, nb, bd, br, to);
        n_tests++;
        if (to || nb != 4 || rd_done !== 1'b1 || rd_err !== ERR_EXP) begin
            n_fail++;
            $display("FAIL err_early_last: timeout=%0d beats=%0d done=%b err=%b, need 0 4 1 %b",
                     to, nb, rd_done, rd_err, ERR_EXP);
        end
        cyc();
        issue(30'h900, 8'd0, 0, arv, a, l);
        recv(0, -1, 1'b0, nb, bd, br, to);
        cyc();
        n_tests++;
        if (rd_err !== ERR_EXP) begin
            n_fail++;
            $display("FAIL err_sticky_clean: err=%b, need %b", rd_err, ERR_EXP);
        end
        do_reset();
        issue(30'hA00, 8'd2, 0, arv, a, l);
        recv(2, -1, 1'b0, nb, bd, br, to);
        cyc();
        n_tests++;
        if (rd_err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_clean_burst: err=%b, need 0", rd_err);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_burst8();
        test_len0();
        test_fifo_full();
        test_back_to_back();
        test_reset_mid();
        test_resp_err();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
